// File: rtl/uc_disk_sequencer_pkg.sv
// Shared definitions for the disk-command sequencer: register offsets, descriptor
// field widths, one-hot sequencer states and the device register address helper.
package uc_disk_sequencer_pkg;

    localparam logic [15:0] IDLE_ADDR   = 16'hFFFF;
    localparam logic [1:0]  DEV_DA_LOW  = 2'd0;
    localparam logic [1:0]  DEV_DA_HI   = 2'd1;
    localparam logic [1:0]  DEV_CMD     = 2'd2;
    localparam logic [1:0]  SEQ_HOLDOFF = 2'd3;

    localparam int DESC_DEV_W   = 3;
    localparam int DESC_DRIVE_W = 3;
    localparam int DESC_CMD_W   = 3;
    localparam int DESC_LBA_W   = 32;

    typedef enum logic [5:0] {
        SEQ_IDLE    = 6'b000001,
        SEQ_REQ     = 6'b000010,
        SEQ_RD_LO   = 6'b000100,
        SEQ_RD_HI   = 6'b001000,
        SEQ_RD_CMD  = 6'b010000,
        SEQ_PRESENT = 6'b100000
    } seq_state_e;

    function automatic logic [15:0] reg_addr(input logic [2:0] dev, input logic [1:0] off);
        return {11'd0, dev, off};
    endfunction

endpackage

// File: rtl/uc_disk_sequencer_rr_pick8.sv
// Combinational round-robin search: first asserted request at or after ptr, modulo 8.
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);

    logic [15:0] dbl_s;
    logic [7:0]  rot_s;
    logic [2:0]  off_s;

    // Rotate so that bit 0 is the device at ptr, then priority-encode from there.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[7:0];
        off_s = 3'd0;
        casez (rot_s)
            8'b???????1: off_s = 3'd0;
            8'b??????10: off_s = 3'd1;
            8'b?????100: off_s = 3'd2;
            8'b????1000: off_s = 3'd3;
            8'b???10000: off_s = 3'd4;
            8'b??100000: off_s = 3'd5;
            8'b?1000000: off_s = 3'd6;
            8'b10000000: off_s = 3'd7;
            default:     off_s = 3'd0;
        endcase
        valid = |req;
        idx   = ptr + off_s;
    end

endmodule

// File: rtl/uc_disk_sequencer.sv
// Services disk-command interrupts: picks a device round-robin, wins the bus, reads
// DA_LOW, DA_HI and CMD, and presents the result as one valid/ready descriptor.
module uc_disk_sequencer
    import uc_disk_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                    uCLK,
    input  logic                    init_n,
    input  logic [7:0]              uINTERRUPT,
    input  logic [7:0]              dev_enable,
    output logic                    bus_req,
    input  logic                    bus_gnt,
    output logic [15:0]             uADDR,
    output logic                    uWRITE,
    input  logic [15:0]             uDATA,
    input  logic                    uWAIT,
    output logic                    desc_valid,
    input  logic                    desc_ready,
    output logic [DESC_DEV_W-1:0]   desc_dev,
    output logic [DESC_DRIVE_W-1:0] desc_drive,
    output logic [DESC_CMD_W-1:0]   desc_cmd,
    output logic [DESC_LBA_W-1:0]   desc_lba,
    output logic                    timeout_err,
    output logic [2:0]              timeout_dev
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    seq_state_e     state_r, state_nx_s;
    logic [2:0]     cur_r, cur_nx_s;
    logic [2:0]     rr_ptr_r, rr_ptr_nx_s;
    logic [WCW-1:0] wait_cnt_r, wait_cnt_nx_s;
    logic [7:0]     sync1_r, pend_r;
    logic [1:0]     holdoff_cnt_r;
    logic [2:0]     holdoff_dev_r;
    logic [7:0]     holdoff_mask_s, eligible_s;
    logic           pick_valid_s;
    logic [2:0]     pick_idx_s;
    logic           rd_done_s, timeout_s;
    logic [15:0]    uaddr_s;

    logic                    desc_valid_r;
    logic [DESC_DEV_W-1:0]   desc_dev_r;
    logic [DESC_DRIVE_W-1:0] desc_drive_r;
    logic [DESC_CMD_W-1:0]   desc_cmd_r;
    logic [DESC_LBA_W-1:0]   desc_lba_r;
    logic                    timeout_err_r;
    logic [2:0]              timeout_dev_r;

    // Eligibility: pending, enabled, and not the device just serviced.
    always_comb begin
        holdoff_mask_s = 8'd0;
        if (holdoff_cnt_r != 2'd0) begin
            holdoff_mask_s = 8'd1 << holdoff_dev_r;
        end else begin
            holdoff_mask_s = 8'd0;
        end
        eligible_s = pend_r & dev_enable & ~holdoff_mask_s;
    end

    rr_pick8 u_pick (
        .req   (eligible_s),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Sequencer next-state logic.
    always_comb begin
        state_nx_s    = state_r;
        cur_nx_s      = cur_r;
        rr_ptr_nx_s   = rr_ptr_r;
        wait_cnt_nx_s = wait_cnt_r;
        rd_done_s     = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (pick_valid_s) begin
                    cur_nx_s   = pick_idx_s;
                    state_nx_s = SEQ_REQ;
                end else begin
                    state_nx_s = SEQ_IDLE;
                end
            end
            SEQ_REQ: begin
                if (bus_gnt) begin
                    state_nx_s    = SEQ_RD_LO;
                    wait_cnt_nx_s = '0;
                end else begin
                    state_nx_s = SEQ_REQ;
                end
            end
            SEQ_RD_LO, SEQ_RD_HI, SEQ_RD_CMD: begin
                // Without the grant the bus is not ours: hold, and do not age the read.
                if (!bus_gnt) begin
                    state_nx_s = state_r;
                end else if (!uWAIT) begin
                    rd_done_s     = 1'b1;
                    wait_cnt_nx_s = '0;
                    case (state_r)
                        SEQ_RD_LO: state_nx_s = SEQ_RD_HI;
                        SEQ_RD_HI: state_nx_s = SEQ_RD_CMD;
                        default:   state_nx_s = SEQ_PRESENT;
                    endcase
                end else if (wait_cnt_r == WCW'(WAIT_LIMIT)) begin
                    timeout_s     = 1'b1;
                    wait_cnt_nx_s = '0;
                    rr_ptr_nx_s   = cur_r + 3'd1;
                    state_nx_s    = SEQ_IDLE;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + WCW'(1);
                end
            end
            SEQ_PRESENT: begin
                if (desc_ready) begin
                    rr_ptr_nx_s = cur_r + 3'd1;
                    state_nx_s  = SEQ_IDLE;
                end else begin
                    state_nx_s = SEQ_PRESENT;
                end
            end
            default: begin
                state_nx_s = SEQ_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge uCLK or negedge init_n) begin
        if (!init_n) begin
            state_r    <= SEQ_IDLE;
            cur_r      <= 3'd0;
            rr_ptr_r   <= 3'd0;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            cur_r      <= cur_nx_s;
            rr_ptr_r   <= rr_ptr_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
        end
    end

    // Interrupt synchronizer and post-CMD hold-off timer.
    always_ff @(posedge uCLK or negedge init_n) begin
        if (!init_n) begin
            sync1_r       <= 8'd0;
            pend_r        <= 8'd0;
            holdoff_cnt_r <= 2'd0;
            holdoff_dev_r <= 3'd0;
        end else begin
            sync1_r <= uINTERRUPT;
            pend_r  <= sync1_r;
            if (rd_done_s && (state_r == SEQ_RD_CMD)) begin
                holdoff_cnt_r <= SEQ_HOLDOFF;
                holdoff_dev_r <= cur_r;
            end else if (holdoff_cnt_r != 2'd0) begin
                holdoff_cnt_r <= holdoff_cnt_r - 2'd1;
            end else begin
                holdoff_cnt_r <= 2'd0;
            end
        end
    end

    // Descriptor capture and timeout reporting.
    always_ff @(posedge uCLK or negedge init_n) begin
        if (!init_n) begin
            desc_valid_r  <= 1'b0;
            desc_dev_r    <= '0;
            desc_drive_r  <= '0;
            desc_cmd_r    <= '0;
            desc_lba_r    <= '0;
            timeout_err_r <= 1'b0;
            timeout_dev_r <= 3'd0;
        end else begin
            desc_valid_r  <= (state_nx_s == SEQ_PRESENT);
            timeout_err_r <= timeout_s;
            if (timeout_s) begin
                timeout_dev_r <= cur_r;
            end else begin
                timeout_dev_r <= timeout_dev_r;
            end
            if (rd_done_s) begin
                case (state_r)
                    SEQ_RD_LO: desc_lba_r[15:0]  <= uDATA;
                    SEQ_RD_HI: desc_lba_r[31:16] <= uDATA;
                    SEQ_RD_CMD: begin
                        desc_dev_r   <= cur_r;
                        desc_drive_r <= uDATA[6:4];
                        desc_cmd_r   <= uDATA[2:0];
                    end
                    default: desc_lba_r <= desc_lba_r;
                endcase
            end else begin
                desc_lba_r <= desc_lba_r;
            end
        end
    end

    // Bus address decoded straight from the one-hot state register.
    always_comb begin
        uaddr_s = IDLE_ADDR;
        case (state_r)
            SEQ_RD_LO:  uaddr_s = reg_addr(cur_r, DEV_DA_LOW);
            SEQ_RD_HI:  uaddr_s = reg_addr(cur_r, DEV_DA_HI);
            SEQ_RD_CMD: uaddr_s = reg_addr(cur_r, DEV_CMD);
            default:    uaddr_s = IDLE_ADDR;
        endcase
    end

    assign uADDR       = uaddr_s;
    assign bus_req     = (state_r == SEQ_REQ) || (state_r == SEQ_RD_LO) ||
                         (state_r == SEQ_RD_HI) || (state_r == SEQ_RD_CMD);
    assign uWRITE      = 1'b0;
    assign desc_valid  = desc_valid_r;
    assign desc_dev    = desc_dev_r;
    assign desc_drive  = desc_drive_r;
    assign desc_cmd    = desc_cmd_r;
    assign desc_lba    = desc_lba_r;
    assign timeout_err = timeout_err_r;
    assign timeout_dev = timeout_dev_r;

endmodule
